seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit, active-low seven-segment display decoder (4-bit num, 3-bit digit select).
- Holds an 8-entry x 4-bit digit register file that software/upstream logic writes.
- A refresh prescaler steps the digit select across digits 0..7 so all digits appear lit.
- Drives num/sel of the decoder plus a blank flag. Integration forces anode to 8'hFF while blank=1.

---
 rtl/seg7_scan_ctrl_if.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 61 ++++++
 tb/tb_seg7_scan_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: digit register file write port
//   wr_en   - write strobe, one digit written per cycle it is high
//   wr_addr - digit index written
//   wr_data - hex value stored at wr_addr
interface seg7_scan_ctrl_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment decoder
//   i_clk        - system clock, rising edge
//   i_rst_n      - synchronous active-low reset
//   wr           - digit register file write port (slave side)
//   i_digit_en   - per-digit enable, bit i low blanks digit i
//   i_lz_en      - leading-zero suppression enable
//   o_num        - hex value of the selected digit
//   o_sel        - selected digit index
//   o_blank      - selected digit must be dark
//   o_frame_done - one-cycle pulse after the scan wraps 7 -> 0
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    seg7_scan_ctrl_if.slave       wr,
    input  logic [NUM_DIGITS-1:0] i_digit_en,
    input  logic                  i_lz_en,
    output logic [3:0]            o_num,
    output logic [2:0]            o_sel,
    output logic                  o_blank,
    output logic                  o_frame_done
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_sel;
    logic                  r_frame_done;
    logic [3:0]            r_digits [NUM_DIGITS];
    logic                  w_tick;
    logic                  w_acc;
    logic [NUM_DIGITS-1:0] w_zero_up;
    assign w_tick = (r_cnt == CW'(REFRESH_DIV - 1));
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_sel        <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= 4'h0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
            r_sel        <= w_tick ? r_sel + 3'd1 : r_sel;
            r_frame_done <= w_tick && (r_sel == 3'(NUM_DIGITS - 1));
            if (wr.wr_en) r_digits[wr.wr_addr] <= wr.wr_data;
        end
    end
    // w_zero_up[i]: digit i and every digit above it hold zero
    always_comb begin
        w_acc     = 1'b1;
        w_zero_up = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc        = w_acc && (r_digits[i] == 4'h0);
            w_zero_up[i] = w_acc;
        end
    end
    assign o_sel        = r_sel;
    assign o_num        = r_digits[r_sel];
    assign o_frame_done = r_frame_done;
    // digit 0 always shows, so a value of zero still displays "0"
    assign o_blank      = ~i_digit_en[r_sel] | (i_lz_en & (r_sel != 3'd0) & w_zero_up[r_sel]);
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized bench for seg7_scan_ctrl against a cycle-count model
module tb_seg7_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] digit_en;
    logic       lz_en;
    logic [3:0] num_a, num_b;
    logic [2:0] sel_a, sel_b;
    logic       blank_a, blank_b, fd_a, fd_b;
    int         n_chk = 0;
    int         n_fail = 0;
    int         k = 0;
    bit         m_valid = 1'b0;
    logic [3:0] m_dig [8];
    logic [3:0] t2 [8] = '{4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
    logic [3:0] t3 [8] = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       t3b [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    seg7_scan_ctrl_if wa();

    seg7_scan_ctrl #(.REFRESH_DIV(4), .NUM_DIGITS(8)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .wr(wa), .i_digit_en(digit_en), .i_lz_en(lz_en),
        .o_num(num_a), .o_sel(sel_a), .o_blank(blank_a), .o_frame_done(fd_a));

    seg7_scan_ctrl #(.REFRESH_DIV(1), .NUM_DIGITS(8)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .wr(wa), .i_digit_en(digit_en), .i_lz_en(lz_en),
        .o_num(num_b), .o_sel(sel_b), .o_blank(blank_b), .o_frame_done(fd_b));

    // model: k counts clock edges since reset; the scan position follows from k alone
    always @(posedge clk) begin
        if (!rst_n) begin
            k       <= 0;
            m_valid <= 1'b1;
            foreach (m_dig[i]) m_dig[i] <= 4'h0;
        end else if (m_valid) begin
            k <= k + 1;
            if (wa.wr_en) m_dig[wa.wr_addr] <= wa.wr_data;
        end
    end

    function automatic logic [2:0] esel(input int div);
        return 3'((k / div) % 8);
    endfunction

    function automatic logic efd(input int div);
        return (k > 0) && (k % (8 * div) == 0);
    endfunction

    function automatic logic eblank(input logic [2:0] s);
        logic supp;
        supp = (s != 3'd0);
        for (int j = int'(s); j < 8; j++) if (m_dig[j] != 4'h0) supp = 1'b0;
        return !digit_en[s] || (lz_en && supp);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (!m_valid) return;
        chk("a_sel", int'(sel_a), int'(esel(4)));
        chk("a_num", int'(num_a), int'(m_dig[esel(4)]));
        chk("a_blank", int'(blank_a), int'(eblank(esel(4))));
        chk("a_frame_done", int'(fd_a), int'(efd(4)));
        chk("b_sel", int'(sel_b), int'(esel(1)));
        chk("b_num", int'(num_b), int'(m_dig[esel(1)]));
        chk("b_blank", int'(blank_b), int'(eblank(esel(1))));
        chk("b_frame_done", int'(fd_b), int'(efd(1)));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_sel(input logic [2:0] s);
        int n;
        n = 0;
        while (sel_a != s && n < 40) begin
            tick();
            n++;
        end
        chk("wait_sel", int'(sel_a), int'(s));
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        wa.wr_en   = 1'b1;
        wa.wr_addr = a;
        wa.wr_data = d;
        tick();
        wa.wr_en   = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n      = 1'b0;
        wa.wr_en   = 1'b0;
        wa.wr_addr = 3'd0;
        wa.wr_data = 4'h0;
        digit_en   = 8'hFF;
        lz_en      = 1'b0;
        tick();
        tick();
        chk("rst_sel", int'(sel_a), 0);
        chk("rst_num", int'(num_a), 0);
        chk("rst_frame_done", int'(fd_a), 0);
        chk("rst_blank", int'(blank_a), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t1_sel_hold", int'(sel_a), 0);
        tick();
        chk("t1_sel_1", int'(sel_a), 1);
        repeat (4) tick();
        chk("t1_sel_2", int'(sel_a), 2);
        for (int i = 0; i < 8; i++) wr(3'(i), t2[i]);
        wait_sel(3'd0);
        chk("t2_frame_pulse", int'(fd_a), 1);
        for (int s = 0; s < 8; s++) begin
            wait_sel(3'(s));
            chk("t2_num", int'(num_a), int'(t2[s]));
        end
        wait_sel(3'd0);
        chk("t2_frame_pulse2", int'(fd_a), 1);
        tick();
        chk("t2_frame_single", int'(fd_a), 0);
        lz_en = 1'b1;
        for (int i = 0; i < 8; i++) wr(3'(i), t3[i]);
        wait_sel(3'd0);
        for (int s = 0; s < 8; s++) begin
            wait_sel(3'(s));
            chk("t3_lz_blank", int'(blank_a), int'(t3b[s]));
        end
        wr(3'd0, 4'h0);
        wr(3'd2, 4'h0);
        wait_sel(3'd0);
        for (int s = 0; s < 8; s++) begin
            wait_sel(3'(s));
            chk("t3_all_zero_blank", int'(blank_a), (s == 0) ? 0 : 1);
        end
        lz_en    = 1'b0;
        digit_en = 8'b1111_1011;
        for (int i = 0; i < 8; i++) wr(3'(i), t2[i]);
        wait_sel(3'd0);
        for (int s = 0; s < 8; s++) begin
            wait_sel(3'(s));
            chk("t4_en_blank", int'(blank_a), (s == 2) ? 1 : 0);
        end
        wait_sel(3'd2);
        cnt = 1;
        while (sel_a == 3'd2 && cnt < 40) begin
            tick();
            if (sel_a == 3'd2) cnt++;
        end
        chk("t4_dwell_sel2", cnt, 4);
        digit_en = 8'hFF;
        wait_sel(3'd5);
        wr(3'd5, 4'h9);
        chk("t5_num_after_write", int'(num_a), 9);
        chk("t5_sel_unchanged", int'(sel_a), 5);
        cnt = 0;
        repeat (16) begin
            tick();
            if (fd_b) cnt++;
        end
        chk("t5_div1_frames", cnt, 2);
        repeat (3000) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            wa.wr_en   = 1'($urandom);
            wa.wr_addr = 3'($urandom);
            wa.wr_data = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            digit_en   = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
            lz_en      = 1'($urandom);
            tick();
        end
        rst_n    = 1'b1;
        wa.wr_en = 1'b0;
        digit_en = 8'hFF;
        lz_en    = 1'b0;
        for (int i = 0; i < 8; i++) wr(3'(i), t2[i]);
        cnt = 0;
        while (k % 32 != 26 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("t6_sync_sel6", int'(sel_a), 6);
        rst_n = 1'b0;
        wr(3'd0, 4'hF);
        rst_n = 1'b1;
        chk("t6_sel_reset", int'(sel_a), 0);
        chk("t6_write_discarded", int'(num_a), 0);
        repeat (3) tick();
        chk("t6_cnt_restart_hold", int'(sel_a), 0);
        tick();
        chk("t6_cnt_restart_step", int'(sel_a), 1);
        repeat (32) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
